// File: rtl/pl_control_mc.sv
// ID-stage control unit: decodes the IF/ID instruction into a registered ID/EX control word
// and sequences multi-cycle MULT/DIV occupancy by freezing the front end while the unit is busy.
module pl_control_mc #(
    parameter int MUL_LAT  = 4,
    parameter int DIV_LAT  = 8,
    parameter int ALU_OP_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                valid_in,
    input  logic                nop,
    input  logic                stall_in,
    input  logic                flush,
    input  logic                clr_exc,
    output logic                jump,
    output logic                branch_eq,
    output logic                branch_ne,
    output logic                alu_src,
    output logic                mem_write,
    output logic                mem_read,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                reg_dst,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                valid_out,
    output logic                mdu_start,
    output logic                stall_out,
    output logic                undefined_instr,
    output logic                exc_sticky,
    output logic                state_dbg,
    output logic [3:0]          cnt_dbg
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] F_MULT   = 6'h18;
    localparam logic [5:0] F_DIV    = 6'h1A;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = '0;
    localparam logic [ALU_OP_W-1:0] ALU_BR  = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_RT  = ALU_OP_W'(2);

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    typedef struct packed {
        logic                jump;
        logic                branch_eq;
        logic                branch_ne;
        logic                alu_src;
        logic                mem_write;
        logic                mem_read;
        logic                mem_to_reg;
        logic                reg_write;
        logic                reg_dst;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    state_t     state;
    logic [3:0] cnt;
    ctrl_t      idex;
    ctrl_t      dec;
    logic       known;
    logic       is_mdu;
    logic [3:0] mdu_cnt;
    logic       accept;

    // Valid semantics: an instruction moves IF/ID -> ID/EX only on accept; valid_out marks a real
    // instruction in ID/EX, and stall_out tells the front end to hold IF/ID while the MDU is busy.
    assign accept = valid_in & ~nop & ~stall_in & ~flush & (state == IDLE);

    always_comb begin
        dec     = '0;
        known   = 1'b1;
        is_mdu  = 1'b0;
        mdu_cnt = (funct == F_DIV) ? DIV_CNT : MUL_CNT;
        case (opcode)
            OP_RTYPE: begin
                dec.alu_op = ALU_RT;
                if (funct == F_MULT || funct == F_DIV) begin
                    is_mdu = 1'b1;
                end else begin
                    dec.reg_dst   = 1'b1;
                    dec.reg_write = 1'b1;
                end
            end
            OP_LW: begin
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.alu_op    = ALU_ADD;
            end
            OP_ADDI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                dec.branch_eq = 1'b1;
                dec.alu_op    = ALU_BR;
            end
            OP_BNE: begin
                dec.branch_ne = 1'b1;
                dec.alu_op    = ALU_BR;
            end
            OP_J:    dec.jump = 1'b1;
            default: known = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex            <= '0;
            valid_out       <= 1'b0;
            mdu_start       <= 1'b0;
            undefined_instr <= 1'b0;
            exc_sticky      <= 1'b0;
            state           <= IDLE;
            cnt             <= 4'd0;
        end else begin
            if (accept && !known) begin
                exc_sticky <= 1'b1;
            end else if (clr_exc) begin
                exc_sticky <= 1'b0;
            end

            if (flush) begin
                idex            <= '0;
                valid_out       <= 1'b0;
                mdu_start       <= 1'b0;
                undefined_instr <= 1'b0;
                state           <= IDLE;
                cnt             <= 4'd0;
            end else if (!stall_in) begin
                idex            <= '0;
                valid_out       <= 1'b0;
                mdu_start       <= 1'b0;
                undefined_instr <= 1'b0;
                if (accept) begin
                    if (!known) begin
                        undefined_instr <= 1'b1;
                    end else begin
                        idex      <= dec;
                        valid_out <= 1'b1;
                        // A latency of 1 finishes within the accept cycle, so no BUSY phase.
                        if (is_mdu) begin
                            mdu_start <= 1'b1;
                            if (mdu_cnt != 4'd0) begin
                                state <= BUSY;
                                cnt   <= mdu_cnt;
                            end
                        end
                    end
                end else if (state == BUSY) begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= IDLE;
                end
            end
        end
    end

    assign jump       = idex.jump;
    assign branch_eq  = idex.branch_eq;
    assign branch_ne  = idex.branch_ne;
    assign alu_src    = idex.alu_src;
    assign mem_write  = idex.mem_write;
    assign mem_read   = idex.mem_read;
    assign mem_to_reg = idex.mem_to_reg;
    assign reg_write  = idex.reg_write;
    assign reg_dst    = idex.reg_dst;
    assign alu_op     = idex.alu_op;
    assign stall_out  = (state == BUSY);
    assign state_dbg  = state;
    assign cnt_dbg    = cnt;

endmodule

// File: tb/tb_pl_control_mc.sv
// Bench for pl_control_mc: directed vectors push hand-computed expected output words into a
// queue; a monitor pops one entry per clock and compares it with the sampled outputs.
module tb_pl_control_mc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       valid_in = 1'b0;
    logic       nop = 1'b0;
    logic       stall_in = 1'b0;
    logic       flush = 1'b0;
    logic       clr_exc = 1'b0;
    logic       jump, branch_eq, branch_ne, alu_src, mem_write, mem_read, mem_to_reg;
    logic       reg_write, reg_dst, valid_out, mdu_start, stall_out, undefined_instr, exc_sticky;
    logic [1:0] alu_op;
    logic       state_dbg;
    logic [3:0] cnt_dbg;

    logic [20:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    // Observed word: {state, cnt, jump, beq, bne, alu_src, mw, mr, m2r, rw, rd, alu_op, valid, mdu_start, stall, undef, sticky}
    logic [20:0] got;
    assign got = {state_dbg, cnt_dbg, jump, branch_eq, branch_ne, alu_src, mem_write, mem_read,
                  mem_to_reg, reg_write, reg_dst, alu_op, valid_out, mdu_start, stall_out,
                  undefined_instr, exc_sticky};

    // Control vector: {rst_n, valid_in, nop, stall_in, flush, clr_exc}
    localparam logic [5:0] C_RST  = 6'b000000;
    localparam logic [5:0] C_IDLE = 6'b100000;
    localparam logic [5:0] C_V    = 6'b110000;
    localparam logic [5:0] C_NOP  = 6'b111000;
    localparam logic [5:0] C_STL  = 6'b110100;
    localparam logic [5:0] C_FL   = 6'b110010;
    localparam logic [5:0] C_CLR  = 6'b100001;
    localparam logic [5:0] C_VCLR = 6'b110001;

    localparam logic [5:0] RT = 6'h00, J = 6'h02, BEQ = 6'h04, BNE = 6'h05;
    localparam logic [5:0] ADDI = 6'h08, LW = 6'h23, SW = 6'h2B, BAD = 6'h3F;
    localparam logic [5:0] F_ADD = 6'h20, F_MULT = 6'h18, F_DIV = 6'h1A;

    pl_control_mc dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .valid_in(valid_in),
        .nop(nop), .stall_in(stall_in), .flush(flush), .clr_exc(clr_exc),
        .jump(jump), .branch_eq(branch_eq), .branch_ne(branch_ne), .alu_src(alu_src),
        .mem_write(mem_write), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .reg_dst(reg_dst), .alu_op(alu_op), .valid_out(valid_out),
        .mdu_start(mdu_start), .stall_out(stall_out), .undefined_instr(undefined_instr),
        .exc_sticky(exc_sticky), .state_dbg(state_dbg), .cnt_dbg(cnt_dbg)
    );

    always #5 clk = ~clk;

    task automatic step(input string nm, input logic [5:0] op, input logic [5:0] fn,
                        input logic [5:0] c, input logic [20:0] e);
        @(negedge clk);
        {rst_n, valid_in, nop, stall_in, flush, clr_exc} = c;
        opcode = op;
        funct  = fn;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        logic [20:0] e;
        string       nm;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", nm, got, e);
                end
            end
        end
    end

    initial begin : stimulus
        step("reset0", 6'h00, 6'h00, C_RST, 21'h000000);
        step("reset1", 6'h00, 6'h00, C_RST, 21'h000000);
        step("lw_first_after_release", LW, 6'h00, C_V, 21'h001710);
        step("sw", SW, 6'h00, C_V, 21'h001810);
        step("addi", ADDI, 6'h00, C_V, 21'h001110);
        step("rtype_add", RT, F_ADD, C_V, 21'h0001D0);
        step("bne", BNE, 6'h00, C_V, 21'h002030);
        step("j", J, 6'h00, C_V, 21'h008010);
        step("no_valid_bubble", LW, 6'h00, C_IDLE, 21'h000000);
        step("nop_bubble", LW, 6'h00, C_NOP, 21'h000000);

        step("beq", BEQ, 6'h00, C_V, 21'h004030);
        for (int i = 0; i < 3; i++) step("beq_stall_hold", LW, 6'h00, C_STL, 21'h004030);
        step("lw_after_stall", LW, 6'h00, C_V, 21'h001710);

        step("mult_start", RT, F_MULT, C_V, 21'h13005C);
        step("mult_busy2", ADDI, 6'h00, C_V, 21'h120004);
        step("mult_busy1", ADDI, 6'h00, C_V, 21'h110004);
        step("mult_done", ADDI, 6'h00, C_V, 21'h000000);
        step("addi_after_mult", ADDI, 6'h00, C_V, 21'h001110);

        step("div_start", RT, F_DIV, C_V, 21'h17005C);
        step("div_busy", ADDI, 6'h00, C_V, 21'h160004);
        step("div_flush", ADDI, 6'h00, C_FL, 21'h000000);
        step("addi_after_flush", ADDI, 6'h00, C_V, 21'h001110);

        step("undef", BAD, 6'h00, C_V, 21'h000003);
        step("undef_sticky1", 6'h00, 6'h00, C_IDLE, 21'h000001);
        step("undef_sticky2", 6'h00, 6'h00, C_IDLE, 21'h000001);
        step("clr_exc", 6'h00, 6'h00, C_CLR, 21'h000000);
        step("undef_with_clr", BAD, 6'h00, C_VCLR, 21'h000003);
        step("j_sticky", J, 6'h00, C_V, 21'h008011);
        step("clr_exc2", 6'h00, 6'h00, C_CLR, 21'h000000);

        step("mult_start2", RT, F_MULT, C_V, 21'h13005C);
        step("mult_stall_hold", ADDI, 6'h00, C_STL, 21'h13005C);
        step("mult2_busy2", ADDI, 6'h00, C_V, 21'h120004);
        step("mult2_busy1", ADDI, 6'h00, C_V, 21'h110004);
        step("mult2_done", ADDI, 6'h00, C_V, 21'h000000);
        step("addi_after_mult2", ADDI, 6'h00, C_V, 21'h001110);
        step("flush_kills_lw", LW, 6'h00, C_FL, 21'h000000);

        step("div2_start", RT, F_DIV, C_V, 21'h17005C);
        step("div2_busy", ADDI, 6'h00, C_V, 21'h160004);
        @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (got !== 21'h000000) begin
            n_fail++;
            $display("FAIL async_reset_mid_busy: got %h expected %h", got, 21'h000000);
        end
        step("reset_held", ADDI, 6'h00, C_RST, 21'h000000);
        step("addi_after_reset", ADDI, 6'h00, C_V, 21'h001110);
        step("final_idle", 6'h00, 6'h00, C_IDLE, 21'h000000);

        repeat (3) @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drained: got %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pl_control_mc.md
PL_CONTROL_MC -- requirements
Module: pl_control_mc

Interface
REQ-001 Parameter MUL_LAT, default 4, cycles a MULT occupies the multiply/divide unit (legal 1..15).
REQ-002 Parameter DIV_LAT, default 8, cycles a DIV occupies the multiply/divide unit (legal 1..15).
REQ-003 Parameter ALU_OP_W, default 2, width of alu_op.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 opcode  in  6  instruction bits [31:26] from IF/ID.
REQ-007 funct  in  6  instruction bits [5:0] from IF/ID.
REQ-008 valid_in  in  1  IF/ID holds a real instruction.
REQ-009 nop  in  1  force a bubble for the current instruction.
REQ-010 stall_in  in  1  downstream stall; ID/EX holds its contents.
REQ-011 flush  in  1  kill the current instruction and abort any multi-cycle operation.
REQ-012 clr_exc  in  1  clears exc_sticky.
REQ-013 jump, branch_eq, branch_ne, alu_src, mem_write, mem_read, mem_to_reg, reg_write, reg_dst  out  1 each  registered ID/EX control word.
REQ-014 alu_op  out  ALU_OP_W  registered ALU operation class.
REQ-015 valid_out  out  1  ID/EX holds a real instruction.
REQ-016 mdu_start  out  1  one-cycle pulse that starts the multiply/divide unit.
REQ-017 stall_out  out  1  freeze PC and IF/ID; combinational from state only.
REQ-018 undefined_instr  out  1  registered one-cycle pulse for an unknown opcode.
REQ-019 exc_sticky  out  1  latched undefined-instruction flag.

Function
REQ-020 Opcode decode: RTYPE 0x00 -> reg_dst, reg_write, alu_op=2'b10.
REQ-021 Opcode decode: LW 0x23 -> alu_src, mem_read, mem_to_reg, reg_write, alu_op=2'b00.
REQ-022 Opcode decode: SW 0x2B -> alu_src, mem_write, alu_op=2'b00.
REQ-023 Opcode decode: ADDI 0x08 -> alu_src, reg_write, alu_op=2'b00.
REQ-024 Opcode decode: BEQ 0x04 -> branch_eq, alu_op=2'b01; BNE 0x05 -> branch_ne, alu_op=2'b01.
REQ-025 Opcode decode: J 0x02 -> jump only.
REQ-026 Every unasserted control bit, and alu_op when no ALU is used, SHALL be 0; outputs are never X.
REQ-027 Accept = valid_in & ~nop & ~stall_in & ~flush & state==IDLE; on accept the decoded word loads into ID/EX with valid_out=1, one-cycle latency.
REQ-028 When ~stall_in, ~flush and accept is false, ID/EX SHALL load a bubble: all controls 0, valid_out 0.
REQ-029 When stall_in & ~flush, ID/EX, undefined_instr, mdu_start and the FSM counter SHALL hold.
REQ-030 flush has top priority: next cycle bubble, state=IDLE, counter=0, no mdu_start.
REQ-031 An unknown opcode on accept SHALL load a bubble, pulse undefined_instr for 1 cycle and set exc_sticky.
REQ-032 exc_sticky clears on clr_exc; a simultaneous set wins over clr_exc.
REQ-033 Funct 0x18 (MULT) or 0x1A (DIV) under RTYPE on accept: load word with reg_write=0 and reg_dst=0, pulse mdu_start, load cnt=LAT-1.
REQ-034 FSM states: IDLE and BUSY; IDLE->BUSY on multi-cycle accept when LAT>1; a LAT of 1 stays in IDLE.
REQ-035 In BUSY cnt decrements each non-stalled cycle; BUSY->IDLE when cnt==1 and decrements.
REQ-036 stall_out = (state==BUSY); bubbles are inserted into ID/EX while BUSY.
REQ-037 cnt width SHALL be 4 bits; no wrap-around; cnt is 0 whenever in IDLE.

Reset
REQ-038 rst_n low SHALL asynchronously force all outputs to 0, state=IDLE, cnt=0, exc_sticky=0, including mid-BUSY.
REQ-039 Release of rst_n is synchronous to clk; the first accept is possible on the first rising edge after release.

Verification
REQ-040 LW (0x23) with valid_in=1 -> next cycle alu_src=mem_read=mem_to_reg=reg_write=1, alu_op=00, valid_out=1.
REQ-041 MULT (0x00/0x18), MUL_LAT=4 -> mdu_start 1 cycle, stall_out=1 for exactly 3 cycles, then ADDI accepted on the following edge.
REQ-042 DIV in BUSY, flush asserted at cycle 2 -> next cycle stall_out=0, valid_out=0, state=IDLE.
REQ-043 opcode 0x3F -> bubble, undefined_instr pulses once, exc_sticky=1 until clr_exc; undefined opcode coincident with clr_exc -> exc_sticky=1.
REQ-044 BEQ loaded, then stall_in=1 for 3 cycles -> branch_eq=1 and valid_out=1 held for all 3 cycles; nop=1 -> bubble.
REQ-045 rst_n pulsed low mid-BUSY, asynchronous to clk -> all outputs 0 immediately; stall_out=0 after release.
